div_issue_ctrl: RTL
===================

// Module: div_issue_ctrl
// PURPOSE
//   Initiator side of the iterative divider handshake (div/div_tready/complete). Sits in EX stage of the
//   MIPS pipeline: accepts DIV/DIVU from the pipeline, issues operands to the divider, waits for the result,
//   commits quotient->LO and remainder->HI, and holds busy so the pipeline stalls meanwhile. Also owns HI/LO
//   for MTHI/MTLO and handles exception flush while a divide is in flight.
// PARAMETERS
//   TIMEOUT_CYCLES  48  max cycles in WAIT/DRAIN before abandoning the op and setting err_timeout
// PORTS
//   clk           in   1   single clock
//   reset         in   1   synchronous reset, active-high
//   req_valid     in   1   DIV/DIVU request from EX
//   req_signed    in   1   1=DIV (signed), 0=DIVU
//   req_x         in   32  dividend (rs)
//   req_y         in   32  divisor (rt)
//   req_ready     out  1   request accepted this cycle when req_valid&&req_ready
//   flush         in   1   exception/eret flush; kills the in-flight divide
//   mthi_we       in   1   MTHI write
//   mtlo_we       in   1   MTLO write
//   mt_data       in   32  MTHI/MTLO data
//   div_valid     out  1   to divider div input (tvalid)
//   div_signed    out  1   to divider
//   div_x, div_y  out  32  operands to divider, stable while div_valid
//   div_tready    in   1   divider accept; handshake = div_valid && div_tready
//   div_s, div_r  in   32  quotient/remainder, valid when div_complete asserted in WAIT/DRAIN
//   div_complete  in   1   divider done (also high when divider idle; meaningful only in WAIT/DRAIN)
//   busy          out  1   state != IDLE; pipeline stall request
//   done          out  1   one-cycle pulse: HI/LO updated from a divide
//   hi, lo        out  32  architectural HI/LO
//   err_timeout   out  1   sticky; set when watchdog fires, cleared only by reset
// BEHAVIOUR
//   Reset: state=IDLE; hi=lo=0; div_valid=0; div_x=div_y=0; div_signed=0; done=0; err_timeout=0; wdog=0.
//   States: IDLE, ISSUE, WAIT, DRAIN. req_ready = (state==IDLE) && !flush.
//   IDLE: req_valid && !flush -> latch x/y/signed into div_x/div_y/div_signed, go ISSUE.
//         mthi_we/mtlo_we honoured only in IDLE (hi/lo <= mt_data next edge); ignored in other states.
//         mt write and req accept in the same cycle: both take effect.
//   ISSUE: div_valid=1, operands held. div_tready -> WAIT (handshake done).
//         flush && !div_tready -> IDLE, no handshake, div_valid drops next cycle.
//         flush && div_tready -> DRAIN (divider already owns the op).
//   WAIT: div_valid=0. div_complete -> lo<=div_s, hi<=div_r, done=1 next cycle, -> IDLE.
//         flush (incl. same cycle as div_complete) -> DRAIN; result discarded, hi/lo untouched.
//   DRAIN: div_complete -> IDLE, no HI/LO write, no done. New requests not accepted.
//   Watchdog: wdog cleared on entry to WAIT/DRAIN, +1 per cycle there; reaching TIMEOUT_CYCLES -> IDLE,
//         err_timeout=1, no HI/LO write.
//   Latency: accept edge -> ISSUE (1 cycle); idle divider handshakes in first ISSUE cycle; done one cycle
//         after div_complete sampled; busy falls same edge as done rises.
//   Divide by zero: no trap; HI/LO take whatever divider returns.
//   Reset mid-op: everything to reset values next edge; divider is reset by the same reset.
// TESTING
//   DIVU 7/2 -> after done: lo=0x00000003, hi=0x00000001; busy high from accept edge until done.
//   DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU same operands -> lo=0x7FFFFFFC, hi=1.
//   flush in ISSUE with div_tready=0 -> IDLE next cycle, no done, hi/lo unchanged, div_valid low.
//   flush 5 cycles into WAIT (hi=lo=0x55) -> DRAIN; on div_complete -> IDLE, hi/lo still 0x55, no done.
//   MTLO 0x1234 while busy -> ignored; in IDLE with req_valid -> lo=0x1234, then divide result overwrites.
//   div_complete never asserted -> IDLE after TIMEOUT_CYCLES in WAIT, err_timeout=1 stays until reset.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: initiator side of the iterative divider handshake.
// Takes DIV/DIVU from EX, hands the operands to the divider, waits for the
// result and commits quotient->LO and remainder->HI. Also owns the
// architectural HI/LO registers for MTHI/MTLO. An exception flush abandons
// the divide. A watchdog stops the controller from waiting forever on a
// divider that never completes.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        req_ready,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic        div_valid,
  output logic        div_signed,
  output logic [31:0] div_x,
  output logic [31:0] div_y,
  input  logic        div_tready,
  input  logic [31:0] div_s,
  input  logic [31:0] div_r,
  input  logic        div_complete,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT_CYCLES - 1);

  state_t         state;
  state_t         state_nx;
  logic [WDW-1:0] wdog;
  logic           accept;
  logic           commit;
  logic           timeout;
  logic           wdog_clr;

  // A new request is taken only in IDLE, and never while a flush is in progress.
  assign req_ready = (state == IDLE) && !flush;

  // Next-state decode plus the one-cycle events it produces.
  // A completion has priority over a timeout that lands in the same cycle.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    commit   = 1'b0;
    timeout  = 1'b0;
    wdog_clr = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end else begin
          state_nx = IDLE;
        end
      end
      ISSUE: begin
        if (div_tready) begin
          // The handshake has happened, so the divider owns the op even if it is flushed.
          wdog_clr = 1'b1;
          state_nx = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_nx = IDLE;
        end else begin
          state_nx = ISSUE;
        end
      end
      WAIT: begin
        if (flush) begin
          wdog_clr = 1'b1;
          state_nx = DRAIN;
        end else if (div_complete) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end else if (wdog == WDOG_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = WAIT;
        end
      end
      DRAIN: begin
        if (div_complete) begin
          state_nx = IDLE;
        end else if (wdog == WDOG_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register, with busy, div_valid and done registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      div_valid   <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != IDLE);
      div_valid   <= (state_nx == ISSUE);
      done        <= commit;
      err_timeout <= err_timeout | timeout;
    end
  end

  // Watchdog: counts the cycles spent in WAIT/DRAIN; it restarts on each entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
    end else if (wdog_clr) begin
      wdog <= '0;
    end else if ((state == WAIT) || (state == DRAIN)) begin
      wdog <= wdog + WDW'(1);
    end else begin
      wdog <= wdog;
    end
  end

  // Operand latch: captured when a request is accepted, held stable while issuing.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_x      <= 32'h0000_0000;
      div_y      <= 32'h0000_0000;
      div_signed <= 1'b0;
    end else if (accept) begin
      div_x      <= req_x;
      div_y      <= req_y;
      div_signed <= req_signed;
    end else begin
      div_x      <= div_x;
      div_y      <= div_y;
      div_signed <= div_signed;
    end
  end

  // HI/LO: written by a committed divide, or by MTHI/MTLO only while IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= 32'h0000_0000;
      lo <= 32'h0000_0000;
    end else if (commit) begin
      lo <= div_s;
      hi <= div_r;
    end else if (state == IDLE) begin
      hi <= mthi_we ? mt_data : hi;
      lo <= mtlo_we ? mt_data : lo;
    end else begin
      hi <= hi;
      lo <= lo;
    end
  end

endmodule
